// File: rtl/cricket_ui_pkg.sv
// rtl/cricket_ui_pkg.sv - shared cricket UI types, default blink timing and sizing helpers
package cricket_ui_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_t;

  // 50 ms at 100 MHz; shared by every LED-facing UI block
  localparam int BLINK_ON_DEF  = 5_000_000;
  localparam int BLINK_GAP_DEF = 5_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stretch_timer.sv
// rtl/stretch_timer.sv - per-state cycle timer with clear and exact terminal-count flag
module stretch_timer
  import cricket_ui_pkg::*;
#(
  parameter int W = cnt_width(BLINK_ON_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  assign o_tc = (r_count == i_limit);

  // Holds at the limit instead of wrapping if the owner forgets to clear
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/blink_stretch.sv
// rtl/blink_stretch.sv - stretches event pulses into queued LED blinks; BLINK_STRETCH_OVF_EN adds overflow flag
module blink_stretch
  import cricket_ui_pkg::*;
#(
  parameter int ON_CYCLES  = BLINK_ON_DEF,
  parameter int GAP_CYCLES = BLINK_GAP_DEF,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending
`ifdef BLINK_STRETCH_OVF_EN
  ,
  output logic              overflow
`endif
);

  localparam int                TW       = cnt_width(max_int(ON_CYCLES, GAP_CYCLES));
  localparam logic [TW-1:0]     ON_LIM   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LIM  = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  blink_state_t      r_state;
  blink_state_t      w_next_state;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_next_pending;
  logic [PEND_W-1:0] w_queued_pending;
  logic              r_led;
  logic              r_busy;
  logic              w_tc;
  logic              w_full;
  logic              w_timer_clear;
  logic [TW-1:0]     w_limit;

  assign w_full           = (r_pending == PEND_MAX);
  assign w_queued_pending = (pulse_in && !w_full) ? r_pending + PEND_W'(1) : r_pending;
  assign w_limit          = (r_state == GAP) ? GAP_LIM : ON_LIM;

  always_comb begin
    w_next_state   = r_state;
    w_next_pending = r_pending;
    case (r_state)
      IDLE: begin
        // A pulse here becomes the blink itself, so it is never queued
        if (pulse_in) begin
          w_next_state = ON;
        end
      end
      ON: begin
        w_next_pending = w_queued_pending;
        if (w_tc) begin
          w_next_state = GAP;
        end
      end
      GAP: begin
        if (w_tc) begin
          if ((r_pending != '0) || pulse_in) begin
            // A pulse arriving now replaces the queued event being consumed
            w_next_state = ON;
            if (!pulse_in) begin
              w_next_pending = r_pending - PEND_W'(1);
            end
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_pending = w_queued_pending;
        end
      end
      default: begin
        w_next_state   = IDLE;
        w_next_pending = '0;
      end
    endcase
  end

  assign w_timer_clear = (w_next_state != r_state) || (r_state == IDLE);

  stretch_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clear),
    .i_en    (1'b1),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  // Outputs decode the next state so the pin toggles straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_next_pending;
      r_led     <= (w_next_state == ON);
      r_busy    <= (w_next_state != IDLE);
    end
  end

  assign led_out = r_led;
  assign busy    = r_busy;
  assign pending = r_pending;

`ifdef BLINK_STRETCH_OVF_EN
  logic w_drop;
  logic r_overflow;

  // The terminal GAP cycle never drops: the pulse takes the consumed slot
  assign w_drop = pulse_in && w_full &&
                  ((r_state == ON) || ((r_state == GAP) && !w_tc));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_blink_stretch.sv
// tb/tb_blink_stretch.sv - randomized and directed self-checking bench for blink_stretch
module tb_blink_stretch;

  localparam int ON_C  = 4;
  localparam int GAP_C = 3;
  localparam int PW    = 2;
  localparam int PMAX  = 3;
  localparam int HN    = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pulse_in = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
`ifdef BLINK_STRETCH_OVF_EN
  logic          overflow;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;

  // Reference model: a blink is described by its start cycle alone
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_queued = 0;
  bit m_ovf    = 1'b0;
  bit e_led    = 1'b0;
  bit e_busy   = 1'b0;
  int e_pend   = 0;

  bit h_led  [HN];
  bit h_busy [HN];
  int h_pend [HN];
  bit h_ovf  [HN];

  always #5 clk = ~clk;

  blink_stretch #(
    .ON_CYCLES  (ON_C),
    .GAP_CYCLES (GAP_C),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending)
`ifdef BLINK_STRETCH_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_active = 1'b0;
      m_queued = 0;
      m_ovf    = 1'b0;
    end else if (m_active) begin
      if (cyc - m_start == ON_C + GAP_C) begin
        if (m_queued > 0 || pulse_in) begin
          m_start = cyc;
          if (!pulse_in) m_queued = m_queued - 1;
        end else begin
          m_active = 1'b0;
        end
      end else if (pulse_in) begin
        if (m_queued == PMAX) m_ovf = 1'b1;
        else m_queued = m_queued + 1;
      end
    end else if (pulse_in) begin
      m_active = 1'b1;
      m_start  = cyc;
    end
    e_busy = m_active;
    e_led  = m_active && (cyc - m_start < ON_C);
    e_pend = m_queued;
  end

  always @(negedge clk) begin
    if (cyc < HN) begin
      h_led[cyc]  = led_out;
      h_busy[cyc] = busy;
      h_pend[cyc] = int'(pending);
`ifdef BLINK_STRETCH_OVF_EN
      h_ovf[cyc]  = overflow;
`else
      h_ovf[cyc]  = 1'b0;
`endif
    end
    check("led_out", int'(led_out), int'(e_led));
    check("busy", int'(busy), int'(e_busy));
    check("pending", int'(pending), e_pend);
`ifdef BLINK_STRETCH_OVF_EN
    check("overflow", int'(overflow), int'(m_ovf));
`endif
  end

  // Value seen at posedge k of the current scenario (k=0 is the reset edge)
  function automatic int led_at(input int k);  return int'(h_led[base + k - 1]);  endfunction
  function automatic int busy_at(input int k); return int'(h_busy[base + k - 1]); endfunction
  function automatic int pend_at(input int k); return h_pend[base + k - 1];       endfunction
  function automatic int ovf_at(input int k);  return int'(h_ovf[base + k - 1]);  endfunction

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic scenario(input logic [63:0] mask, input int rst_at, input int len);
    @(negedge clk);
    reset    = 1'b1;
    pulse_in = 1'b0;
    @(negedge clk);
    base = cyc;
    for (int k = 1; k <= len; k++) begin
      pulse_in = mask[k];
      reset    = (k == rst_at);
      @(negedge clk);
    end
    pulse_in = 1'b0;
    reset    = 1'b0;
  endtask

  function automatic int count_blinks(input int len);
    int n;
    n = 0;
    for (int k = 2; k <= len; k++) begin
      if (led_at(k) == 1 && led_at(k - 1) == 0) n++;
    end
    return n;
  endfunction

  initial begin
    int density;
    repeat (2) @(negedge clk);
    check("reset_led", int'(led_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pending", int'(pending), 0);

    scenario(bits(10, 10), -1, 24);
    check("t1_led10", led_at(10), 0);
    check("t1_led11", led_at(11), 1);
    check("t1_led14", led_at(14), 1);
    check("t1_led15", led_at(15), 0);
    check("t1_busy17", busy_at(17), 1);
    check("t1_busy18", busy_at(18), 0);
    check("t1_pend12", pend_at(12), 0);

    scenario(bits(10, 12), -1, 36);
    check("t2_pend12", pend_at(12), 1);
    check("t2_pend13", pend_at(13), 2);
    check("t2_led17", led_at(17), 0);
    check("t2_led18", led_at(18), 1);
    check("t2_pend18", pend_at(18), 1);
    check("t2_led25", led_at(25), 1);
    check("t2_pend25", pend_at(25), 0);
    check("t2_busy31", busy_at(31), 1);
    check("t2_busy32", busy_at(32), 0);

    scenario(bits(10, 15), -1, 45);
    check("t3_pend14", pend_at(14), 3);
    check("t3_blinks", count_blinks(45), 4);
    check("t3_busy39", busy_at(39), 0);
`ifdef BLINK_STRETCH_OVF_EN
    check("t3_ovf14", ovf_at(14), 0);
    check("t3_ovf15", ovf_at(15), 1);
    check("t3_ovf45", ovf_at(45), 1);
`endif

    scenario(bits(10, 11) | bits(13, 13), 12, 24);
    check("t4_pend12", pend_at(12), 1);
    check("t4_led13", led_at(13), 0);
    check("t4_busy13", busy_at(13), 0);
    check("t4_pend13", pend_at(13), 0);
    check("t4_led14", led_at(14), 1);
    check("t4_led17", led_at(17), 1);
    check("t4_led18", led_at(18), 0);

    scenario(bits(10, 10) | bits(17, 17), -1, 30);
    check("t5_led17", led_at(17), 0);
    check("t5_busy17", busy_at(17), 1);
    check("t5_led18", led_at(18), 1);
    check("t5_busy18", busy_at(18), 1);
    check("t5_pend18", pend_at(18), 0);
    check("t5_busy25", busy_at(25), 0);

    scenario(bits(10, 13) | bits(17, 17), -1, 50);
    check("t6_pend17", pend_at(17), 3);
    check("t6_led18", led_at(18), 1);
    check("t6_pend18", pend_at(18), 3);
    check("t6_blinks", count_blinks(50), 5);
`ifdef BLINK_STRETCH_OVF_EN
    check("t6_ovf18", ovf_at(18), 0);
`endif

    // Random phase: bursts of varying density with occasional resets
    @(negedge clk);
    reset = 1'b0;
    density = 20;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 3))
          0:       density = 3;
          1:       density = 15;
          2:       density = 45;
          default: density = 90;
        endcase
      end
      pulse_in = ($urandom_range(0, 99) < density);
      reset    = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    pulse_in = 1'b0;
    reset    = 1'b0;
    repeat (40) @(negedge clk);
    check("final_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
